// File: rtl/sram_stream_reader_if.sv
// Valid/ready word stream from the SRAM reader to the MAC datapath.
interface sram_stream_reader_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/sram_stream_reader.sv
// Read-side sequencer for a single-port SRAM macro: walks a wrap-around address
// range, absorbs the one-cycle read latency and streams words out through a small FIFO.
module sram_stream_reader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W:0]     len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                sram_ceb_o,
  output logic                sram_web_o,
  output logic [ADDR_W-1:0]   sram_a_o,
  input  logic [DATA_W-1:0]   sram_q_i,
  sram_stream_reader_if.master stream_o
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    issue_left_q, issue_left_d;
  logic [LEN_W-1:0]    pop_left_q, pop_left_d;
  logic                inflight_q;
  logic                done_q, done_d;
  logic                issue_c;
  logic                pop_c;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CRD_W-1:0]    occupied_c, room_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_c      = (count_q != '0) && stream_o.ready;
  // Credit check: count + inflight < FIFO_DEPTH + pop, so the FIFO can never overflow.
  assign occupied_c = CRD_W'(count_q) + CRD_W'(inflight_q);
  assign room_c     = CRD_W'(FIFO_DEPTH) + CRD_W'(pop_c);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    done_d       = 1'b0;
    issue_c      = 1'b0;
    if (pop_c) pop_left_d = pop_left_q - LEN_W'(1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d       = base_addr_i;
            issue_left_d = len_i;
            pop_left_d   = len_i;
            state_d      = RUN;
          end
        end
      end
      RUN: begin
        if ((issue_left_q != '0) && (occupied_c < room_c)) begin
          issue_c      = 1'b1;
          addr_d       = addr_q + ADDR_W'(1);
          issue_left_d = issue_left_q - LEN_W'(1);
          if (issue_left_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_c && (pop_left_q == LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      inflight_q   <= issue_c;
      done_q       <= done_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({inflight_q, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output FIFO: push the macro's read data one cycle after each issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= sram_q_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign sram_ceb_o     = ~issue_c;
  assign sram_web_o     = 1'b1;
  assign sram_a_o       = addr_q;
  assign stream_o.data  = mem_q[rd_ptr_q];
  assign stream_o.valid = (count_q != '0);

endmodule
